// File: rtl/nb_force_writeback_buffer.sv
// nb_force_writeback_buffer
//
// Purpose: takes the per-pair force from the RL force evaluation unit,
// negates it (Newton's 3rd law) so it acts on the neighbour particle, and
// queues the neighbour force write in a show-ahead FIFO. The FIFO drains
// to the neighbour force cache over valid/ready. almost_full is raised
// early enough to stall the pair generator before in-flight pipeline
// results can overflow the buffer.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      pair force valid
//   in_nb_id      neighbour full ID {cell z,y,x, particle}
//   in_force      pair force {x,y,z} acting on the reference particle
//   out_valid     head entry available
//   out_ready     force cache accepts the head entry
//   out_nb_id     head neighbour ID
//   out_force     head (negated) force
//   almost_full   back-pressure to the pair generator
//   empty         FIFO empty (used by the phase/reference-switch drain check)
//   count         current occupancy
//   overflow      sticky: a valid input was dropped because the FIFO was full

package md_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CELL_W     = 3;
  localparam int PART_W     = 7;

  typedef struct packed {
    logic [CELL_W-1:0] cell_z;
    logic [CELL_W-1:0] cell_y;
    logic [CELL_W-1:0] cell_x;
    logic [PART_W-1:0] particle;
  } full_id_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
    logic [DATA_WIDTH-1:0] z;
  } data_tuple_t;

endpackage

module nb_force_writeback_buffer #(
  parameter int DEPTH      = 32,
  parameter int AF_MARGIN  = 24,
  parameter int DATA_WIDTH = md_pkg::DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  md_pkg::full_id_t           in_nb_id,
  input  md_pkg::data_tuple_t        in_force,
  output logic                       out_valid,
  input  logic                       out_ready,
  output md_pkg::full_id_t           out_nb_id,
  output md_pkg::data_tuple_t        out_force,
  output logic                       almost_full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_MARGIN);

  typedef struct packed {
    md_pkg::full_id_t    nb_id;
    md_pkg::data_tuple_t frc;
  } entry_t;

  entry_t              mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  md_pkg::data_tuple_t neg_force;
  logic                is_full;
  logic                push;
  logic                pop;
  logic [CNT_W-1:0]    free_slots;

  // Negation is a pure sign-bit flip per component, so +0 becomes -0 and
  // NaNs keep their payload with the sign inverted.
  always_comb begin
    neg_force                = in_force;
    neg_force.x[DATA_WIDTH-1] = ~in_force.x[DATA_WIDTH-1];
    neg_force.y[DATA_WIDTH-1] = ~in_force.y[DATA_WIDTH-1];
    neg_force.z[DATA_WIDTH-1] = ~in_force.z[DATA_WIDTH-1];
  end

  // A full FIFO still accepts a write when the head is leaving in the
  // same cycle; the new entry lands in the slot being freed.
  assign is_full   = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~is_full | pop);

  // Show-ahead: the head is read straight out of the array. The write is
  // clocked, so a same-cycle write to the head slot cannot disturb the
  // value presented this cycle.
  assign out_nb_id = mem[rd_ptr].nb_id;
  assign out_force = mem[rd_ptr].frc;

  assign free_slots  = DEPTH_C - count;
  assign almost_full = (free_slots <= AF_C);
  assign empty       = (count == '0);

  // Storage array is deliberately not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= '{nb_id: in_nb_id, frc: neg_force};
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two). Inputs arriving
  // during reset are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (in_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nb_force_writeback_buffer.sv
// tb_nb_force_writeback_buffer
//
// Purpose: self-checking bench for nb_force_writeback_buffer. Uses a table
// of directed vectors, hand-written multi-cycle sequences for the FIFO
// corner cases, and a randomized run compared against a queue-based
// reference model of the buffer.

module tb_nb_force_writeback_buffer;
  import md_pkg::*;

  localparam int DEPTH     = 32;
  localparam int AF_MARGIN = 24;
  localparam int CNT_W     = $clog2(DEPTH+1);
  localparam logic [3*DATA_WIDTH-1:0] SIGN_MASK =
    {3{1'b1, {(DATA_WIDTH-1){1'b0}}}};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  full_id_t    in_nb_id;
  data_tuple_t in_force;
  logic        out_valid;
  logic        out_ready;
  full_id_t    out_nb_id;
  data_tuple_t out_force;
  logic        almost_full;
  logic        empty;
  logic [CNT_W-1:0] count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    full_id_t    nb_id;
    data_tuple_t frc;
  } entry_t;

  // Reference model: an ordered list of pending writes plus a sticky flag.
  entry_t model_q[$];
  logic   model_ovf = 1'b0;

  typedef struct {
    logic        v;
    logic        r;
    logic [15:0] id;
    logic [95:0] f;
    logic        e_valid;
    int          e_count;
    logic [15:0] e_id;
    logic [95:0] e_f;
  } vec_t;

  vec_t vecs[8];

  nb_force_writeback_buffer #(
    .DEPTH(DEPTH),
    .AF_MARGIN(AF_MARGIN),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_nb_id(in_nb_id),
    .in_force(in_force),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_nb_id(out_nb_id),
    .out_force(out_force),
    .almost_full(almost_full),
    .empty(empty),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic data_tuple_t negate(input data_tuple_t f);
    return data_tuple_t'(f ^ SIGN_MASK);
  endfunction

  function automatic full_id_t mkId(input int i);
    return full_id_t'(16'(i));
  endfunction

  function automatic data_tuple_t randForce();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, advances the model by the same cycle, and
  // leaves time #1 after the edge so outputs can be sampled.
  task automatic applyStimulus(input logic v, input logic r, input full_id_t id,
                               input data_tuple_t f);
    bit pop_m;
    bit push_m;
    in_valid  = v;
    out_ready = r;
    in_nb_id  = id;
    in_force  = f;
    pop_m  = (model_q.size() != 0) && r;
    push_m = v && ((model_q.size() < DEPTH) || pop_m);
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (pop_m) void'(model_q.pop_front());
      if (push_m) model_q.push_back({id, negate(f)});
      if (v && !push_m) model_ovf = 1'b1;
    end
  endtask

  task automatic applyReset(input logic v, input full_id_t id);
    rst = 1'b1;
    applyStimulus(v, 1'b0, id, randForce());
    rst = 1'b0;
  endtask

  task automatic checkModel(input string tag);
    int n;
    n = model_q.size();
    checkOutput({tag, ".out_valid"}, 128'(out_valid), 128'(n != 0));
    checkOutput({tag, ".count"}, 128'(count), 128'(n));
    checkOutput({tag, ".empty"}, 128'(empty), 128'(n == 0));
    checkOutput({tag, ".almost_full"}, 128'(almost_full),
                128'((DEPTH - n) <= AF_MARGIN));
    checkOutput({tag, ".overflow"}, 128'(overflow), 128'(model_ovf));
    if (n != 0) begin
      checkOutput({tag, ".head_id"}, 128'(out_nb_id), 128'(model_q[0].nb_id));
      checkOutput({tag, ".head_force"}, 128'(out_force), 128'(model_q[0].frc));
    end
  endtask

  initial begin
    int pops;
    bit seen_beef;
    int rdy_pct;
    int val_pct;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_nb_id  = '0;
    in_force  = '0;

    // Directed vectors: {in_valid, out_ready, id, force, exp valid, exp count, exp head}
    vecs[0] = '{1'b1, 1'b0, 16'h0123, {32'h3F800000, 32'hC0000000, 32'h00000000},
                1'b1, 1, 16'h0123, {32'hBF800000, 32'h40000000, 32'h80000000}};
    vecs[1] = '{1'b1, 1'b0, 16'h0456, {32'h00000000, 32'h7FC00000, 32'h80000000},
                1'b1, 2, 16'h0123, {32'hBF800000, 32'h40000000, 32'h80000000}};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 96'h0,
                1'b1, 1, 16'h0456, {32'h80000000, 32'hFFC00000, 32'h00000000}};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 96'h0, 1'b0, 0, 16'h0, 96'h0};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 96'h0, 1'b0, 0, 16'h0, 96'h0};
    vecs[5] = '{1'b1, 1'b1, 16'h0ABC, {32'hFFFFFFFF, 32'h00000001, 32'h7F800000},
                1'b1, 1, 16'h0ABC, {32'h7FFFFFFF, 32'h80000001, 32'hFF800000}};
    vecs[6] = '{1'b1, 1'b1, 16'h0DEF, {32'h12345678, 32'h80000000, 32'h3F800000},
                1'b1, 1, 16'h0DEF, {32'h92345678, 32'h00000000, 32'hBF800000}};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 96'h0, 1'b0, 0, 16'h0, 96'h0};

    $display("[TB] reset");
    applyReset(1'b0, mkId(0));
    applyReset(1'b0, mkId(0));
    checkOutput("reset.out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset.empty", 128'(empty), 128'(1));
    checkOutput("reset.almost_full", 128'(almost_full), 128'(0));
    checkOutput("reset.count", 128'(count), 128'(0));
    checkOutput("reset.overflow", 128'(overflow), 128'(0));

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].v, vecs[i].r, full_id_t'(vecs[i].id),
                    data_tuple_t'(vecs[i].f));
      checkOutput($sformatf("vec%0d.out_valid", i), 128'(out_valid),
                  128'(vecs[i].e_valid));
      checkOutput($sformatf("vec%0d.count", i), 128'(count),
                  128'(vecs[i].e_count));
      checkOutput($sformatf("vec%0d.empty", i), 128'(empty),
                  128'(vecs[i].e_count == 0));
      checkOutput($sformatf("vec%0d.almost_full", i), 128'(almost_full), 128'(0));
      if (vecs[i].e_valid) begin
        checkOutput($sformatf("vec%0d.head_id", i), 128'(out_nb_id),
                    128'(vecs[i].e_id));
        checkOutput($sformatf("vec%0d.head_force", i), 128'(out_force),
                    128'(vecs[i].e_f));
      end
    end

    $display("[TB] burst with back-pressure");
    applyReset(1'b0, mkId(0));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, mkId(16'h0200 + i), randForce());
      checkModel("burst.fill");
      checkOutput("burst.head_stalled", 128'(out_nb_id), 128'(16'h0200));
    end
    applyStimulus(1'b0, 1'b0, mkId(0), randForce());
    checkOutput("burst.head_held", 128'(out_nb_id), 128'(16'h0200));
    checkOutput("burst.count_held", 128'(count), 128'(8));
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        checkOutput("burst.order", 128'(out_nb_id), 128'(16'h0200 + pops));
        pops++;
      end
      applyStimulus(1'b0, 1'b1, mkId(0), randForce());
      checkModel("burst.drain");
    end
    checkOutput("burst.pops", 128'(pops), 128'(8));
    checkOutput("burst.empty", 128'(empty), 128'(1));
    checkOutput("burst.count", 128'(count), 128'(0));

    $display("[TB] almost_full threshold");
    applyReset(1'b0, mkId(0));
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, mkId(16'h0300 + i), randForce());
    checkOutput("af.count7", 128'(count), 128'(7));
    checkOutput("af.low_at7", 128'(almost_full), 128'(0));
    applyStimulus(1'b1, 1'b0, mkId(16'h0307), randForce());
    checkOutput("af.count8", 128'(count), 128'(8));
    checkOutput("af.high_at8", 128'(almost_full), 128'(1));
    applyStimulus(1'b0, 1'b1, mkId(0), randForce());
    checkOutput("af.low_after_pop", 128'(almost_full), 128'(0));
    checkModel("af");

    $display("[TB] full with simultaneous push and pop");
    applyReset(1'b0, mkId(0));
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, mkId(16'h0400 + i), randForce());
    checkOutput("full.count", 128'(count), 128'(DEPTH));
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, mkId(16'h0500 + i), randForce());
      checkModel("full.pushpop");
    end
    checkOutput("full.count_kept", 128'(count), 128'(DEPTH));
    checkOutput("full.no_overflow", 128'(overflow), 128'(0));
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'b0, 1'b1, mkId(0), randForce());
      checkModel("full.drain");
    end

    $display("[TB] overflow");
    applyReset(1'b0, mkId(0));
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, mkId(16'h1000 + i), randForce());
    applyStimulus(1'b1, 1'b0, mkId(16'hBEEF), randForce());
    checkOutput("ovf.count", 128'(count), 128'(DEPTH));
    checkOutput("ovf.flag", 128'(overflow), 128'(1));
    applyStimulus(1'b0, 1'b0, mkId(0), randForce());
    checkOutput("ovf.sticky_idle", 128'(overflow), 128'(1));
    seen_beef = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (out_valid && out_nb_id == mkId(16'hBEEF)) seen_beef = 1'b1;
      applyStimulus(1'b0, 1'b1, mkId(0), randForce());
      checkModel("ovf.drain");
    end
    checkOutput("ovf.dropped_not_seen", 128'(seen_beef), 128'(0));
    checkOutput("ovf.sticky_drained", 128'(overflow), 128'(1));
    checkOutput("ovf.empty", 128'(empty), 128'(1));

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, mkId(16'h0600 + i), randForce());
    checkOutput("rstmid.count5", 128'(count), 128'(5));
    applyReset(1'b1, mkId(16'h06FF));
    checkOutput("rstmid.count", 128'(count), 128'(0));
    checkOutput("rstmid.out_valid", 128'(out_valid), 128'(0));
    checkOutput("rstmid.overflow", 128'(overflow), 128'(0));
    checkOutput("rstmid.empty", 128'(empty), 128'(1));
    applyStimulus(1'b1, 1'b0, mkId(16'h0777), randForce());
    checkOutput("rstmid.next_count", 128'(count), 128'(1));
    checkOutput("rstmid.next_head", 128'(out_nb_id), 128'(16'h0777));
    applyStimulus(1'b0, 1'b1, mkId(0), randForce());
    checkOutput("rstmid.alone", 128'(count), 128'(0));
    checkModel("rstmid");

    $display("[TB] randomized run against reference model");
    applyReset(1'b0, mkId(0));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ((cyc / 200) % 3)
        0:       begin rdy_pct = 15; val_pct = 80; end
        1:       begin rdy_pct = 50; val_pct = 50; end
        default: begin rdy_pct = 90; val_pct = 30; end
      endcase
      if ($urandom_range(0, 499) == 0) begin
        applyReset($urandom_range(0, 1) == 1, mkId($urandom_range(0, 65535)));
      end else begin
        applyStimulus($urandom_range(0, 99) < val_pct, $urandom_range(0, 99) < rdy_pct,
                      mkId($urandom_range(0, 65535)), randForce());
      end
      checkModel("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nb_force_writeback_buffer.md
Name:
nb_force_writeback_buffer

Overview:
- Sits directly downstream of the RL force evaluation unit.
- Consumes its per-pair outputs: out_neighbor_particle_id, out_RL_Force and out_forceoutput_valid.
- Negates each pair force (Newton's 3rd law) and buffers the neighbour-particle force writes in a show-ahead FIFO.
- Drains the FIFO to the neighbour force cache over a valid/ready handshake, and raises almost_full early enough to stall the pair generator before in-flight pipeline results can overflow.

Parameters:
- DEPTH, 32: FIFO entries; power of 2, >= 4.
- AF_MARGIN, 24: almost_full asserts when free slots <= AF_MARGIN. Covers filter + force pipeline in-flight pairs; must be < DEPTH.
- DATA_WIDTH, 32: float width per component; taken from md_pkg.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pair force valid (from out_forceoutput_valid).
- in_nb_id  in  $bits(full_id_t)  neighbour full ID {cell z,y,x, particle}.
- in_force  in  $bits(data_tuple_t)  pair force {x,y,z}, IEEE-754, acting on the reference particle.
- out_valid  out  1  head entry available.
- out_ready  in  1  force cache accepts the head entry.
- out_nb_id  out  $bits(full_id_t)  head neighbour ID.
- out_force  out  $bits(data_tuple_t)  head negated force.
- almost_full  out  1  back-pressure to the pair generator.
- empty  out  1  FIFO empty; feeds the phase/reference-switch drain check.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky error: a valid input was dropped.

Behaviour:
Storage and negation:
- Storage is a circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping naturally modulo DEPTH, plus a separate occupancy counter `count`.
- Negation happens at write time: invert bit DATA_WIDTH-1 of each of the x, y and z components. There is no other arithmetic.
  - +0 becomes -0 (0x00000000 -> 0x80000000).
  - NaN passes through with its sign flipped.

Output (show-ahead):
- out_valid = (count != 0).
- out_nb_id and out_force are driven combinationally from mem[rd_ptr].
- When count == 0, out_nb_id and out_force are don't-care.

Handshake:
- pop = out_valid & out_ready.
- push = in_valid & (count != DEPTH | pop).
- On push: write mem[wr_ptr], then wr_ptr++.
- On pop: rd_ptr++.
- Next count = count + push - pop.

Boundary cases:
- Full with simultaneous push and pop: both occur, count stays at DEPTH. The new entry is written to the slot being freed, and it must not corrupt the head data presented that cycle.
- Empty with in_valid: there is no bypass. The entry is written, and out_valid rises in the next cycle, so write-to-output latency is 1 cycle.
- Full with in_valid and no pop: the input is dropped, pointers and count are unchanged, and overflow is set and held until rst.
- out_ready while empty: no effect.

Flags:
- almost_full = ((DEPTH - count) <= AF_MARGIN).
- empty = (count == 0).
- Both flags are combinational from the count register, so they update in the cycle after a push or pop.

Handshake stability:
- out_valid must not drop without a pop.
- The head data must remain stable while out_valid & ~out_ready.

Reset:
- Reset takes effect on the clock edge.
- wr_ptr, rd_ptr, count and overflow clear to 0.
- Resulting outputs: out_valid=0, empty=1, almost_full=0 (provided AF_MARGIN < DEPTH), count=0, overflow=0.
- Memory contents are not reset.
- Reset mid-operation discards all stored entries, and any in_valid in the reset cycle is ignored.

Test Plan:
1. Write one entry:
   - Stimulus: after reset, in_valid=1 for 1 cycle with in_nb_id=0x0123 and in_force={3F800000, C0000000, 00000000}.
   - Response: next cycle out_valid=1, out_force={BF800000, 40000000, 80000000}, out_nb_id=0x0123, count=1, empty=0.
2. Burst with back-pressure:
   - Stimulus: push 8 distinct entries with out_ready=0, then set out_ready=1.
   - Response: exactly 8 pops in write order, head stable while stalled, then empty=1 and count=0.
3. almost_full threshold (DEPTH=32, AF_MARGIN=24):
   - Stimulus: push 7 entries, then an 8th.
   - Response: almost_full=0 with count=7; almost_full=1 once count=8; deasserts after one pop.
4. Full with simultaneous push and pop:
   - Stimulus: fill to 32, then hold in_valid=1 and out_ready=1 for 40 cycles.
   - Response: count stays at 32, overflow=0, output sequence in order with no loss.
5. Overflow:
   - Stimulus: at count=32 with out_ready=0, push entry 0xBEEF.
   - Response: count=32, overflow=1 and sticky, 0xBEEF never appears at the output.
6. Reset mid-burst:
   - Stimulus: count=5, assert rst for 1 cycle while in_valid=1.
   - Response: count=0, out_valid=0, overflow=0, empty=1, and the next push emerges alone.
